// File: rtl/vai_pkg.sv
// Shared types for the per-sub-AFU request translator: FSM states, CCI-P request header layouts,
// address width and the almost-full slack a sub-AFU is allowed after almfull asserts.
package vai_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    QUIESCE = 2'd1,
    HOLD    = 2'd2
  } t_vai_state;

  localparam int VAI_ALMFULL_SLACK = 8;
  localparam int VAI_ADDR_W        = 42;
  localparam int VAI_DATA_W        = 512;

  typedef logic [VAI_ADDR_W-1:0] t_vai_addr;

  // c0 memory read request header
  typedef struct packed {
    logic [1:0] vc_sel;
    logic [1:0] rsvd1;
    logic [1:0] cl_len;
    logic [3:0] req_type;
    logic [5:0] rsvd0;
    t_vai_addr  address;
    logic [15:0] mdata;
  } t_vai_c0_req_hdr;

  // c1 memory write request header
  typedef struct packed {
    logic [5:0] rsvd2;
    logic [1:0] vc_sel;
    logic       sop;
    logic       rsvd1;
    logic [1:0] cl_len;
    logic [3:0] req_type;
    logic [5:0] rsvd0;
    t_vai_addr  address;
    logic [15:0] mdata;
  } t_vai_c1_req_hdr;

  localparam int VAI_C0_HDR_W = $bits(t_vai_c0_req_hdr);
  localparam int VAI_C1_HDR_W = $bits(t_vai_c1_req_hdr);

  // Cache-line address relocation; wraps silently at 2^VAI_ADDR_W.
  function automatic t_vai_addr vai_xlate_addr(input t_vai_addr addr, input t_vai_addr offset);
    return addr + offset;
  endfunction

endpackage

// File: rtl/vai_outstanding_ctr.sv
// Saturating up/down counter of in-flight requests; next value is exposed so the owner can act on
// the post-update count in the same cycle. o_err pulses on any clamp (overflow or underflow).
module vai_outstanding_ctr #(
  parameter int OUTS_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        i_inc,
  input  logic [2:0]        i_dec,
  output logic [OUTS_W-1:0] o_count,
  output logic [OUTS_W-1:0] o_count_next,
  output logic              o_err
);

  localparam int SUM_W = OUTS_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {OUTS_W{1'b1}}};

  logic [OUTS_W-1:0] r_count;
  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  w_dec;
  logic [SUM_W-1:0]  w_diff;

  always_comb begin
    w_sum        = {2'b00, r_count} + {{(SUM_W-2){1'b0}}, i_inc};
    w_dec        = {{(SUM_W-3){1'b0}}, i_dec};
    w_diff       = w_sum - w_dec;
    o_count_next = w_diff[OUTS_W-1:0];
    o_err        = 1'b0;
    if (w_sum < w_dec) begin
      o_count_next = '0;
      o_err        = 1'b1;
    end else if (w_diff > CNT_MAX) begin
      o_count_next = {OUTS_W{1'b1}};
      o_err        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_count <= '0;
    else       r_count <= o_count_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/vai_sub_afu_xlate.sv
// Per-sub-AFU request translator: relocates c0/c1 addresses by the sub-AFU offset, tracks outstanding
// requests and sequences RUN -> QUIESCE -> HOLD on reset request. Optional VAI_XLATE_STATS_EN adds counters.
module vai_sub_afu_xlate
  import vai_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 8,
  parameter int OUTS_W       = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             i_offset,
  input  logic                    i_sub_rst_req,
  input  logic                    i_sub_tx_c0_valid,
  input  logic [VAI_C0_HDR_W-1:0] i_sub_tx_c0_hdr,
  input  logic                    i_sub_tx_c1_valid,
  input  logic [VAI_C1_HDR_W-1:0] i_sub_tx_c1_hdr,
  input  logic [VAI_DATA_W-1:0]   i_sub_tx_c1_data,
  output logic [1:0]              o_sub_almfull,
  input  logic [1:0]              i_up_almfull,
  output logic                    o_up_tx_c0_valid,
  output logic [VAI_C0_HDR_W-1:0] o_up_tx_c0_hdr,
  output logic                    o_up_tx_c1_valid,
  output logic [VAI_C1_HDR_W-1:0] o_up_tx_c1_hdr,
  output logic [VAI_DATA_W-1:0]   o_up_tx_c1_data,
  output logic                    o_up_tx_c2_valid,
  output logic [8:0]              o_up_tx_c2_hdr,
  output logic [63:0]             o_up_tx_c2_data,
  input  logic                    i_rsp_rx_c0_rsp_valid,
  input  logic                    i_rsp_rx_c1_rsp_valid,
  input  logic                    i_rsp_rx_c1_format,
  input  logic [1:0]              i_rsp_rx_c1_cl_num,
  output logic                    o_sub_rst_out,
  output logic                    o_drained,
  output logic                    o_err_sticky
`ifdef VAI_XLATE_STATS_EN
  ,
  output logic [31:0]             o_stat_rd,
  output logic [31:0]             o_stat_wr
`endif
);

  t_vai_state        r_state;
  t_vai_state        w_state_next;
  logic [3:0]        r_q_cyc;
  logic              r_err_sticky;
  logic              w_fwd_c0;
  logic              w_fwd_c1;
  logic              w_late_req;
  logic [1:0]        w_inc;
  logic [2:0]        w_dec;
  logic [OUTS_W-1:0] w_count;
  logic [OUTS_W-1:0] w_count_next;
  logic              w_cnt_err;
  logic              w_unused;

  logic              r_up_c0_vld;
  logic              r_up_c1_vld;
  t_vai_c0_req_hdr   r_up_c0_hdr;
  t_vai_c1_req_hdr   r_up_c1_hdr;
  logic [VAI_DATA_W-1:0] r_up_c1_dat;
  t_vai_c0_req_hdr   w_c0_xlate;
  t_vai_c1_req_hdr   w_c1_xlate;

  assign w_unused = &{1'b0, i_offset[63:VAI_ADDR_W], (NUM_SUB_AFUS > 0)};

  assign w_fwd_c0 = (r_state == RUN) && i_sub_tx_c0_valid;
  assign w_fwd_c1 = (r_state == RUN) && i_sub_tx_c1_valid;
  // Requests within the almfull slack window after entering QUIESCE are legal and silently dropped.
  assign w_late_req = (r_state == QUIESCE) && (i_sub_tx_c0_valid || i_sub_tx_c1_valid) &&
                      (r_q_cyc > 4'(VAI_ALMFULL_SLACK));

  assign w_inc = {1'b0, w_fwd_c0} + {1'b0, w_fwd_c1};

  always_comb begin
    w_dec = {2'b00, i_rsp_rx_c0_rsp_valid};
    if (i_rsp_rx_c1_rsp_valid) begin
      w_dec = w_dec + (i_rsp_rx_c1_format ? ({1'b0, i_rsp_rx_c1_cl_num} + 3'd1) : 3'd1);
    end
  end

  vai_outstanding_ctr #(
    .OUTS_W (OUTS_W)
  ) u_outs (
    .clk          (clk),
    .reset        (reset),
    .i_inc        (w_inc),
    .i_dec        (w_dec),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_err        (w_cnt_err)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= HOLD;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    o_sub_almfull = 2'b11;
    o_sub_rst_out = 1'b0;
    case (r_state)
      RUN: begin
        o_sub_almfull = i_up_almfull;
        if (i_sub_rst_req) w_state_next = QUIESCE;
      end
      QUIESCE: begin
        if (w_count_next == '0) w_state_next = HOLD;
      end
      HOLD: begin
        o_sub_rst_out = 1'b1;
        if (!i_sub_rst_req) w_state_next = RUN;
      end
      default: w_state_next = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != QUIESCE) r_q_cyc <= '0;
    else if (r_q_cyc != 4'hF)         r_q_cyc <= r_q_cyc + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_err_sticky <= 1'b0;
    else       r_err_sticky <= r_err_sticky | w_cnt_err | w_late_req;
  end

  always_comb begin
    w_c0_xlate         = i_sub_tx_c0_hdr;
    w_c0_xlate.address = vai_xlate_addr(w_c0_xlate.address, i_offset[VAI_ADDR_W-1:0]);
    w_c1_xlate         = i_sub_tx_c1_hdr;
    w_c1_xlate.address = vai_xlate_addr(w_c1_xlate.address, i_offset[VAI_ADDR_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_up_c0_vld <= 1'b0;
      r_up_c1_vld <= 1'b0;
      r_up_c0_hdr <= '0;
      r_up_c1_hdr <= '0;
      r_up_c1_dat <= '0;
    end else begin
      r_up_c0_vld <= w_fwd_c0;
      r_up_c1_vld <= w_fwd_c1;
      if (w_fwd_c0) r_up_c0_hdr <= w_c0_xlate;
      if (w_fwd_c1) begin
        r_up_c1_hdr <= w_c1_xlate;
        r_up_c1_dat <= i_sub_tx_c1_data;
      end
    end
  end

  assign o_up_tx_c0_valid = r_up_c0_vld;
  assign o_up_tx_c0_hdr   = r_up_c0_hdr;
  assign o_up_tx_c1_valid = r_up_c1_vld;
  assign o_up_tx_c1_hdr   = r_up_c1_hdr;
  assign o_up_tx_c1_data  = r_up_c1_dat;
  assign o_up_tx_c2_valid = 1'b0;
  assign o_up_tx_c2_hdr   = '0;
  assign o_up_tx_c2_data  = '0;
  assign o_drained        = (w_count == '0);
  assign o_err_sticky     = r_err_sticky;

`ifdef VAI_XLATE_STATS_EN
  logic        w_hold_to_run;
  logic [31:0] r_stat_rd;
  logic [31:0] r_stat_wr;

  assign w_hold_to_run = (r_state == HOLD) && (w_state_next == RUN);

  always_ff @(posedge clk) begin
    if (reset || w_hold_to_run) begin
      r_stat_rd <= '0;
      r_stat_wr <= '0;
    end else begin
      r_stat_rd <= r_stat_rd + {31'd0, w_fwd_c0};
      r_stat_wr <= r_stat_wr + {31'd0, w_fwd_c1};
    end
  end

  assign o_stat_rd = r_stat_rd;
  assign o_stat_wr = r_stat_wr;
`endif

endmodule
